// File: rtl/crack_scheduler.sv
// Purpose : keyspace scheduler; latches the ciphertext, deals chunk indices to idle
//           search engines round-robin, reports the first hit or keyspace exhaustion.
// Latency : data_valid -> first eng_start 2 edges; eng_found -> rdy 1 edge; last eng_done -> rdy 1 edge.
// Backpressure: none; an engine is only started while its busy bit is clear, one start per cycle.
// Ports   : clk/rst (sync, active low); start, data_valid/data from the reader;
//           eng_start/eng_base/eng_data/eng_abort to the engines; eng_done/eng_found/eng_key
//           back from them; rdy/found/result job status. All outputs are registered.
module crack_scheduler #(
   parameter int N_ENG      = 4,
   parameter int CIDX_W     = 8,
   parameter int NUM_CHUNKS = 256,
   parameter int KEY_W      = 128
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   data_valid,
   input  logic [63:0]            data,
   output logic [N_ENG-1:0]       eng_start,
   output logic [CIDX_W-1:0]      eng_base,
   output logic [63:0]            eng_data,
   output logic                   eng_abort,
   input  logic [N_ENG-1:0]       eng_done,
   input  logic [N_ENG-1:0]       eng_found,
   input  logic [N_ENG*KEY_W-1:0] eng_key,
   output logic                   rdy,
   output logic                   found,
   output logic [KEY_W-1:0]       result
);

   localparam int RR_W = (N_ENG > 1) ? $clog2(N_ENG) : 1;
   // One extra bit so the counter can sit at NUM_CHUNKS without wrapping.
   localparam logic [CIDX_W:0] CNT_MAX = (CIDX_W+1)'(NUM_CHUNKS);

   typedef enum logic [2:0] {S_IDLE, S_WAIT_DATA, S_RUN, S_DONE, S_FAIL} state_t;

   state_t              state_q, state_d;
   logic [N_ENG-1:0]    busy_q, busy_d;
   logic [CIDX_W:0]     cnt_q, cnt_d;
   logic [RR_W-1:0]     rr_q, rr_d;
   logic [N_ENG-1:0]    eng_start_q, eng_start_d;
   logic [CIDX_W-1:0]   eng_base_q, eng_base_d;
   logic [63:0]         eng_data_q, eng_data_d;
   logic                eng_abort_q, eng_abort_d;
   logic                rdy_q, rdy_d;
   logic                found_q, found_d;
   logic [KEY_W-1:0]    result_q, result_d;

   logic [N_ENG-1:0]    hit;
   logic [RR_W-1:0]     win_idx;
   logic                pick_ok;
   logic [RR_W-1:0]     pick_idx;

   // Hits only count from engines we actually started.
   assign hit = eng_found & busy_q;

   always_comb begin
      win_idx = '0;
      for (int i = N_ENG-1; i >= 0; i--) begin
         if (hit[i]) win_idx = RR_W'(i);
      end
   end

   // Candidates come from busy_q, so an engine released this cycle waits one cycle.
   always_comb begin
      pick_ok  = 1'b0;
      pick_idx = '0;
      for (int i = 0; i < N_ENG; i++) begin
         if (!pick_ok && !busy_q[(int'(rr_q) + i) % N_ENG]) begin
            pick_ok  = 1'b1;
            pick_idx = RR_W'((int'(rr_q) + i) % N_ENG);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      cnt_d       = cnt_q;
      rr_d        = rr_q;
      eng_start_d = '0;
      eng_base_d  = eng_base_q;
      eng_data_d  = eng_data_q;
      eng_abort_d = 1'b0;
      rdy_d       = rdy_q;
      found_d     = found_q;
      result_d    = result_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_WAIT_DATA;
         end
         S_WAIT_DATA: begin
            if (data_valid) begin
               eng_data_d = data;
               cnt_d      = '0;
               rr_d       = '0;
               busy_d     = '0;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            if (|hit) begin
               result_d    = eng_key[int'(win_idx)*KEY_W +: KEY_W];
               found_d     = 1'b1;
               rdy_d       = 1'b1;
               eng_abort_d = 1'b1;
               busy_d      = '0;
               state_d     = S_DONE;
            end else begin
               busy_d = busy_q & ~eng_done;
               if (cnt_q < CNT_MAX && pick_ok) begin
                  eng_start_d[pick_idx] = 1'b1;
                  eng_base_d            = cnt_q[CIDX_W-1:0];
                  busy_d[pick_idx]      = 1'b1;
                  cnt_d                 = cnt_q + (CIDX_W+1)'(1);
                  rr_d                  = RR_W'((int'(pick_idx) + 1) % N_ENG);
               end
               if (cnt_d == CNT_MAX && busy_d == '0) begin
                  rdy_d    = 1'b1;
                  found_d  = 1'b0;
                  result_d = '0;
                  state_d  = S_FAIL;
               end
            end
         end
         S_DONE, S_FAIL: begin
            if (start) begin
               rdy_d    = 1'b0;
               found_d  = 1'b0;
               result_d = '0;
               state_d  = S_WAIT_DATA;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         busy_q      <= '0;
         cnt_q       <= '0;
         rr_q        <= '0;
         eng_start_q <= '0;
         eng_base_q  <= '0;
         eng_data_q  <= '0;
         eng_abort_q <= 1'b0;
         rdy_q       <= 1'b0;
         found_q     <= 1'b0;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         cnt_q       <= cnt_d;
         rr_q        <= rr_d;
         eng_start_q <= eng_start_d;
         eng_base_q  <= eng_base_d;
         eng_data_q  <= eng_data_d;
         eng_abort_q <= eng_abort_d;
         rdy_q       <= rdy_d;
         found_q     <= found_d;
         result_q    <= result_d;
      end
   end

   assign eng_start = eng_start_q;
   assign eng_base  = eng_base_q;
   assign eng_data  = eng_data_q;
   assign eng_abort = eng_abort_q;
   assign rdy       = rdy_q;
   assign found     = found_q;
   assign result    = result_q;

endmodule

// File: tb/tb_crack_scheduler.sv
// Directed bench: instance a (4 engines, 6 chunks) covers fill, refill, rotation, hit,
// restart and mid-run reset; instance b (2 engines, 2 chunks) covers exhaustion.
module tb_crack_scheduler;

   logic         clk = 1'b0;
   logic         rst;
   always #5 clk = ~clk;

   // instance a
   logic         a_start, a_dv;
   logic [63:0]  a_data;
   logic [3:0]   a_eng_start;
   logic [7:0]   a_eng_base;
   logic [63:0]  a_eng_data;
   logic         a_eng_abort;
   logic [3:0]   a_done, a_found;
   logic [511:0] a_key;
   logic         a_rdy, a_fnd;
   logic [127:0] a_result;

   // instance b
   logic         b_start, b_dv;
   logic [63:0]  b_data;
   logic [1:0]   b_eng_start;
   logic [7:0]   b_eng_base;
   logic [63:0]  b_eng_data;
   logic         b_eng_abort;
   logic [1:0]   b_done, b_found;
   logic [255:0] b_key;
   logic         b_rdy, b_fnd;
   logic [127:0] b_result;

   int checks = 0;
   int errors = 0;

   crack_scheduler #(.N_ENG(4), .CIDX_W(8), .NUM_CHUNKS(6), .KEY_W(128)) u_a (
      .clk(clk), .rst(rst), .start(a_start), .data_valid(a_dv), .data(a_data),
      .eng_start(a_eng_start), .eng_base(a_eng_base), .eng_data(a_eng_data),
      .eng_abort(a_eng_abort), .eng_done(a_done), .eng_found(a_found), .eng_key(a_key),
      .rdy(a_rdy), .found(a_fnd), .result(a_result));

   crack_scheduler #(.N_ENG(2), .CIDX_W(8), .NUM_CHUNKS(2), .KEY_W(128)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .data_valid(b_dv), .data(b_data),
      .eng_start(b_eng_start), .eng_base(b_eng_base), .eng_data(b_eng_data),
      .eng_abort(b_eng_abort), .eng_done(b_done), .eng_found(b_found), .eng_key(b_key),
      .rdy(b_rdy), .found(b_fnd), .result(b_result));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   localparam logic [127:0] KEY1 = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] KEY3 = {16{8'hAA}};

   initial begin
      rst = 1'b0;
      a_start = 0; a_dv = 0; a_data = '0; a_done = '0; a_found = '0; a_key = '0;
      b_start = 0; b_dv = 0; b_data = '0; b_done = '0; b_found = '0; b_key = '0;
      tick(); tick();
      chk("rst_rdy",       128'(a_rdy), 128'd0);
      chk("rst_found",     128'(a_fnd), 128'd0);
      chk("rst_result",    a_result, 128'd0);
      chk("rst_eng_start", 128'(a_eng_start), 128'd0);
      chk("rst_eng_base",  128'(a_eng_base), 128'd0);
      chk("rst_eng_data",  128'(a_eng_data), 128'd0);
      chk("rst_abort",     128'(a_eng_abort), 128'd0);
      rst = 1'b1;

      // Fill
      a_start = 1; tick(); a_start = 0;
      a_dv = 1; a_data = 64'hDEADBEEF01234567; tick(); a_dv = 0; a_data = '0;
      chk("fill_eng_data", 128'(a_eng_data), 128'h0000000000000000DEADBEEF01234567);
      chk("fill_no_start_yet", 128'(a_eng_start), 128'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("fill_start%0d", i), 128'(a_eng_start), 128'(4'b0001 << i));
         chk($sformatf("fill_base%0d", i),  128'(a_eng_base), 128'(i));
      end
      tick(); chk("fill_idle1", 128'(a_eng_start), 128'd0);
      tick(); chk("fill_idle2", 128'(a_eng_start), 128'd0);

      // Refill and rotation
      a_done = 4'b0100; tick(); a_done = '0;
      chk("refill_not_same", 128'(a_eng_start), 128'd0);
      tick();
      chk("refill_start", 128'(a_eng_start), 128'h4);
      chk("refill_base",  128'(a_eng_base), 128'd4);
      a_done = 4'b1001; tick(); a_done = '0;
      chk("rot_not_same", 128'(a_eng_start), 128'd0);
      tick();
      chk("rot_start", 128'(a_eng_start), 128'h8);
      chk("rot_base",  128'(a_eng_base), 128'd5);
      tick();
      chk("rot_cnt_sat", 128'(a_eng_start), 128'd0);
      chk("rot_no_rdy",  128'(a_rdy), 128'd0);

      // Simultaneous hit, engines 1 and 3 (both busy); lowest index wins
      a_key[1*128 +: 128] = KEY1;
      a_key[3*128 +: 128] = KEY3;
      a_found = 4'b1010; tick(); a_found = '0;
      chk("hit_result", a_result, KEY1);
      chk("hit_found",  128'(a_fnd), 128'd1);
      chk("hit_rdy",    128'(a_rdy), 128'd1);
      chk("hit_abort",  128'(a_eng_abort), 128'd1);
      chk("hit_no_start", 128'(a_eng_start), 128'd0);
      tick();
      chk("abort_pulse", 128'(a_eng_abort), 128'd0);
      chk("hit_hold_result", a_result, KEY1);
      a_done = 4'b1111; tick(); a_done = '0;
      chk("done_ignored_rdy",    128'(a_rdy), 128'd1);
      chk("done_ignored_found",  128'(a_fnd), 128'd1);
      chk("done_ignored_result", a_result, KEY1);
      chk("done_ignored_start",  128'(a_eng_start), 128'd0);

      // Restart
      a_start = 1; tick(); a_start = 0;
      chk("restart_rdy",    128'(a_rdy), 128'd0);
      chk("restart_found",  128'(a_fnd), 128'd0);
      chk("restart_result", a_result, 128'd0);
      a_dv = 1; a_data = 64'h0123456789ABCDEF; tick(); a_dv = 0;
      chk("restart_data", 128'(a_eng_data), 128'h00000000000000000123456789ABCDEF);
      tick();
      chk("restart_start", 128'(a_eng_start), 128'h1);
      chk("restart_base",  128'(a_eng_base), 128'd0);

      // Mid-run reset
      rst = 1'b0; tick(); tick(); tick();
      chk("mrst_rdy",    128'(a_rdy), 128'd0);
      chk("mrst_found",  128'(a_fnd), 128'd0);
      chk("mrst_result", a_result, 128'd0);
      chk("mrst_start",  128'(a_eng_start), 128'd0);
      chk("mrst_abort",  128'(a_eng_abort), 128'd0);
      rst = 1'b1;
      a_dv = 1; tick(); a_dv = 0; tick(); tick();
      chk("mrst_idle_start", 128'(a_eng_start), 128'd0);
      chk("mrst_idle_data",  128'(a_eng_data), 128'd0);

      // Exhaustion on instance b
      b_key = {KEY3, KEY1};
      b_start = 1; tick(); b_start = 0;
      b_dv = 1; b_data = 64'hCAFEF00D12345678; tick(); b_dv = 0;
      tick();
      chk("ex_start0", 128'(b_eng_start), 128'h1);
      chk("ex_base0",  128'(b_eng_base), 128'd0);
      tick();
      chk("ex_start1", 128'(b_eng_start), 128'h2);
      chk("ex_base1",  128'(b_eng_base), 128'd1);
      tick();
      chk("ex_start_none", 128'(b_eng_start), 128'd0);
      b_done = 2'b01; tick(); b_done = '0;
      chk("ex_not_yet", 128'(b_rdy), 128'd0);
      // found from idle engine 0 is ignored; done from engine 1 finishes the job
      b_found = 2'b01; b_done = 2'b10; tick(); b_found = '0; b_done = '0;
      chk("ex_rdy",    128'(b_rdy), 128'd1);
      chk("ex_found",  128'(b_fnd), 128'd0);
      chk("ex_result", b_result, 128'd0);
      chk("ex_abort",  128'(b_eng_abort), 128'd0);
      tick();
      chk("ex_hold_rdy", 128'(b_rdy), 128'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
